// File: rtl/if_fetch_queue_if.sv
// Fetch-to-decode handshake bundle: enqueue side from fetch, dequeue side to decode.
interface if_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // valid/ready: a transfer happens on the rising edge where both are high;
    // ready never depends combinationally on the partner's valid.
    logic          enq_valid;
    logic [15:0]   enq_pc;
    logic [15:0]   enq_instr;
    logic          enq_ready;
    logic          deq_valid;
    logic [15:0]   deq_pc;
    logic [15:0]   deq_instr;
    logic [2:0]    deq_dest;
    logic [2:0]    deq_src1;
    logic [2:0]    deq_src2;
    logic          deq_ready;
    logic          flush;
    logic [CW-1:0] count;

    modport master (
        output enq_valid, enq_pc, enq_instr, deq_ready, flush,
        input  enq_ready, deq_valid, deq_pc, deq_instr, deq_dest, deq_src1, deq_src2, count
    );

    modport slave (
        input  enq_valid, enq_pc, enq_instr, deq_ready, flush,
        output enq_ready, deq_valid, deq_pc, deq_instr, deq_dest, deq_src1, deq_src2, count
    );
endinterface

// File: rtl/if_fetch_queue.sv
// In-order instruction fetch queue; presents the oldest entry to decode with
// register fields pre-sliced, and drops everything on a redirect flush.
module if_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    if_fetch_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } entry_t;

    entry_t [DEPTH-1:0] slots_q, slots_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               enq_fire;
    logic               deq_fire;
    entry_t             head;

    // Readiness uses only registered occupancy, so a full queue stays closed
    // even when decode drains the head in the same cycle.
    always_comb begin
        q.enq_ready = (count_q != FULL) && reset_n && !q.flush;
        q.deq_valid = (count_q != '0) && !q.flush;
        enq_fire    = q.enq_valid && q.enq_ready;
        deq_fire    = q.deq_valid && q.deq_ready;

        head        = slots_q[rd_ptr_q];
        q.deq_pc    = head.pc;
        q.deq_instr = head.instr;
        q.deq_dest  = head.instr[11:9];
        q.deq_src1  = head.instr[8:6];
        q.deq_src2  = head.instr[2:0];
        q.count     = count_q;
    end

    always_comb begin
        slots_d  = slots_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (q.flush) begin
            // Slot contents are left alone; only the bookkeeping is cleared.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) begin
                slots_d[wr_ptr_q] = '{pc: q.enq_pc, instr: q.enq_instr};
                wr_ptr_d          = wr_ptr_q + AW'(1);
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (enq_fire && !deq_fire) begin
                count_d = count_q + CW'(1);
            end else if (deq_fire && !enq_fire) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slots_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slots_q  <= slots_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed test-plan sequences plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_if_fetch_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    // Reference model: FIFO of {pc, instr} pairs in arrival order.
    logic [31:0] exp_q[$];
    bit          head_zero;

    if_fetch_queue_if #(.DEPTH(DEPTH)) fq ();

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (fq.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic cycle(input bit ev, input logic [15:0] pc, input logic [15:0] instr,
                         input bit dr, input bit fl, input bit rn);
        bit          exp_ev, exp_dv, enq_f, deq_f;
        logic [31:0] h;
        fq.enq_valid = ev;
        fq.enq_pc    = pc;
        fq.enq_instr = instr;
        fq.deq_ready = dr;
        fq.flush     = fl;
        reset_n      = rn;
        @(negedge clk);
        exp_ev = rn && !fl && (exp_q.size() != DEPTH);
        exp_dv = !fl && (exp_q.size() != 0);
        check("enq_ready", 32'(fq.enq_ready), 32'(exp_ev));
        check("deq_valid", 32'(fq.deq_valid), 32'(exp_dv));
        check("count", 32'(fq.count), 32'(exp_q.size()));
        if (exp_dv) begin
            h = exp_q[0];
            check("deq_pc", 32'(fq.deq_pc), 32'(h[31:16]));
            check("deq_instr", 32'(fq.deq_instr), 32'(h[15:0]));
            check("deq_dest", 32'(fq.deq_dest), 32'(h[11:9]));
            check("deq_src1", 32'(fq.deq_src1), 32'(h[8:6]));
            check("deq_src2", 32'(fq.deq_src2), 32'(h[2:0]));
        end else if (head_zero) begin
            check("stale_pc_zero", 32'(fq.deq_pc), 32'h0);
            check("stale_instr_zero", 32'(fq.deq_instr), 32'h0);
        end
        enq_f = ev && exp_ev;
        deq_f = dr && exp_dv;
        if (!rn) begin
            exp_q.delete();
            head_zero = 1'b1;
        end else if (fl) begin
            exp_q.delete();
        end else begin
            if (deq_f) void'(exp_q.pop_front());
            if (enq_f) begin
                exp_q.push_back({pc, instr});
                head_zero = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit dr);
        cycle(1'b0, 16'h0, 16'h0, dr, 1'b0, 1'b1);
    endtask

    task automatic push(input logic [15:0] pc, input logic [15:0] instr, input bit dr);
        cycle(1'b1, pc, instr, dr, 1'b0, 1'b1);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        head_zero = 1'b1;
        fq.enq_valid = 1'b0;
        fq.enq_pc    = '0;
        fq.enq_instr = '0;
        fq.deq_ready = 1'b0;
        fq.flush     = 1'b0;
        reset_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Post-reset state
        idle(1'b0);

        // Fill and drain
        for (int i = 0; i < DEPTH; i++) push(16'h3000 + 16'(2 * i), 16'(i) << 9, 1'b0);
        push(16'h3008, 16'h0, 1'b0);
        check("full_count", 32'(fq.count), 32'd4);
        check("full_enq_ready", 32'(fq.enq_ready), 32'd0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Field extraction: ADD R1, R2, R3
        push(16'h3100, 16'h1283, 1'b0);
        check("fx_dest", 32'(fq.deq_dest), 32'd1);
        check("fx_src1", 32'(fq.deq_src1), 32'd2);
        check("fx_src2", 32'(fq.deq_src2), 32'd3);
        idle(1'b1);

        // Streaming across pointer wrap
        for (int i = 0; i < 10; i++) push(16'h3200 + 16'(2 * i), 16'($urandom), 1'b1);
        check("stream_count", 32'(fq.count), 32'd1);
        idle(1'b1);

        // Full with simultaneous dequeue
        for (int i = 0; i < DEPTH; i++) push(16'h3300 + 16'(2 * i), 16'($urandom), 1'b0);
        push(16'h33F0, 16'h0, 1'b1);
        check("full_deq_count", 32'(fq.count), 32'd3);

        // Flush with an enqueue offered in the same cycle
        cycle(1'b1, 16'h4000, 16'h0, 1'b1, 1'b1, 1'b1);
        check("flush_count", 32'(fq.count), 32'd0);
        push(16'h5000, 16'h0, 1'b0);
        check("post_flush_pc", 32'(fq.deq_pc), 32'h5000);
        idle(1'b1);

        // Reset mid-stream at count = 2
        push(16'h6000, 16'h1111, 1'b0);
        push(16'h6002, 16'h2222, 1'b0);
        cycle(1'b1, 16'h6004, 16'h3333, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        check("rst_count", 32'(fq.count), 32'd0);
        check("rst_deq_pc", 32'(fq.deq_pc), 32'h0);
        check("rst_enq_ready", 32'(fq.enq_ready), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 63) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction fetch queue between the fetch stage and decode in the pipelined LC-3b. Each cycle, fetch offers one fetched instruction word with its PC. The queue buffers up to DEPTH entries in order and presents the oldest to decode, with register specifier fields pre-extracted. The buffer decouples decode stalls from instruction-memory reads and discards all queued entries on a control-flow redirect.

## Interface
- DEPTH, 4, number of entries; power of two, >= 2
- clk  input  1  rising-edge clock
- reset_n  input  1  reset; synchronous, active-low
- enq_valid  input  1  fetch presents a valid instruction this cycle
- enq_pc  input  16  PC of the offered instruction (lc3b_word)
- enq_instr  input  16  offered instruction word (lc3b_word)
- enq_ready  output  1  queue accepts an enqueue this cycle
- deq_valid  output  1  head entry valid for decode
- deq_pc  output  16  PC of head entry
- deq_instr  output  16  instruction word of head entry
- deq_dest  output  3  deq_instr[11:9] (lc3b_reg)
- deq_src1  output  3  deq_instr[8:6] (lc3b_reg)
- deq_src2  output  3  deq_instr[2:0] (lc3b_reg)
- deq_ready  input  1  decode consumes the head this cycle
- flush  input  1  redirect (taken branch / JMP / TRAP); discard all entries
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage:
  - Circular buffer of DEPTH {pc, instr} pairs.
  - Write pointer and read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register tracks occupancy.
- Enqueue fires when enq_valid && enq_ready. It writes the slot at the write pointer and advances the write pointer.
- Dequeue fires when deq_valid && deq_ready. It advances the read pointer.
- count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue.
- enq_ready = (count != DEPTH) && reset_n && !flush.
  - Depends only on registered state, flush and reset_n. There is no combinational path from deq_ready.
  - When full, a same-cycle dequeue does not open a slot for enqueue.
- deq_valid = (count != 0) && !flush.
- deq_pc and deq_instr come from the slot at the read pointer. deq_dest, deq_src1 and deq_src2 are pure slices of deq_instr.
- When deq_valid is low, the deq_* data outputs show the stale head slot. Decode must ignore them.
- Flush has highest priority:
  - On the next edge, count, the write pointer and the read pointer all become 0.
  - Any enqueue or dequeue offered in the flush cycle is discarded, because enq_ready and deq_valid are forced low.
  - Slot contents are not cleared.
- Empty with a simultaneous enqueue: there is no bypass. The entry appears on deq_* the following cycle.
- Dequeue while empty or enqueue while full cannot fire, by construction. count never underflows or exceeds DEPTH.

## Timing
- Reset (reset_n low at an edge) sets:
  - count = 0, both pointers = 0, every slot = 16'h0000 / 16'h0000.
  - After that edge: deq_valid = 0, deq_pc = deq_instr = 16'h0000, deq_dest = deq_src1 = deq_src2 = 3'b000, enq_ready = 1.
- While reset_n is low, enq_ready = 0. Reset overrides flush and all handshakes.
- Enqueue-to-visible latency is 1 cycle. An entry enqueued at edge N is on deq_* with deq_valid = 1 after edge N.
- Throughput is one enqueue and one dequeue per cycle while 0 < count < DEPTH.
- Flush asserted in cycle N:
  - deq_valid and enq_ready are low during cycle N.
  - The queue is empty after edge N.
  - An enqueue in cycle N+1 is accepted normally.
- Reset asserted mid-operation discards all entries at that edge, identically to flush, and additionally zeroes the slots.

## Test plan
- **Fill and drain.** With deq_ready = 0, enqueue PCs 16'h3000, 3002, 3004, 3006 (DEPTH = 4).
  - Required: count = 4 and enq_ready = 0.
  - Raise deq_ready: deq_pc sequence is 3000, 3002, 3004, 3006, then deq_valid = 0.
- **Field extraction.** Enqueue instr 16'h1283 (ADD R1, R2, R3).
  - Required next cycle: deq_dest = 3'd1, deq_src1 = 3'd2, deq_src2 = 3'd3.
- **Streaming and wrap.** Hold enq_valid and deq_ready high for 10 cycles with incrementing PCs.
  - Required: steady state count = 1, no drops, deq_pc lags enq_pc by exactly one cycle, and correct order across pointer wrap.
- **Full with simultaneous dequeue.** At count = 4, assert enq_valid and deq_ready.
  - Required: dequeue fires, enqueue does not (enq_ready = 0), and count = 3 next cycle.
- **Flush.** With count = 3, assert flush together with enq_valid (PC 16'h4000).
  - Required: deq_valid = 0 and enq_ready = 0 that cycle; count = 0 next cycle; 4000 is never dequeued.
  - Enqueue 16'h5000 the following cycle: it appears on deq_pc one cycle later.
- **Reset mid-stream.** Drive reset_n low for one edge at count = 2.
  - Required: count = 0, deq_valid = 0, deq_pc = 16'h0000, and enq_ready = 0 during reset, 1 after.
